// File: rtl/reimu_hit_detect_if.sv
`default_nettype none
// ============================================================================
// Module   : reimu_hit_detect_if
// Purpose  : Bullet-pool read/retire bus between the hit detector and the pool.
// Revision : 1.0
// ============================================================================
interface reimu_hit_detect_if #(
  parameter int N_BULLET = 8
) ();
  localparam int IW = $clog2(N_BULLET);

  logic [IW-1:0] bullet_idx;
  logic          bullet_valid;
  logic [9:0]    bullet_x;
  logic [9:0]    bullet_y;
  logic          kill;
  logic [IW-1:0] kill_idx;

  modport master (
    output bullet_idx,
    output kill,
    output kill_idx,
    input  bullet_valid,
    input  bullet_x,
    input  bullet_y
  );

  modport slave (
    input  bullet_idx,
    input  kill,
    input  kill_idx,
    output bullet_valid,
    output bullet_x,
    output bullet_y
  );
endinterface
`default_nettype wire

// File: rtl/reimu_hit_detect.sv
`default_nettype none
// ============================================================================
// Module   : reimu_hit_detect
// Purpose  : Per-frame scan of the enemy-bullet pool against Reimu's hitbox,
//            emitting shot/kill pulses with a shot hold-off window.
// Revision : 1.0
// ============================================================================
module reimu_hit_detect #(
  parameter int N_BULLET = 8,
  parameter int HIT_R    = 4,
  parameter int HOLDOFF  = 80
) (
  input  wire logic        clk_22,
  input  wire logic        rst,
  input  wire logic        frame_tick,
  input  wire logic        player_alive,
  input  wire logic [9:0]  px,
  input  wire logic [9:0]  py,
  reimu_hit_detect_if.master pool,
  output logic             shot,
  output logic             busy
);
  localparam int IW = $clog2(N_BULLET);
  localparam int HW = $clog2(HOLDOFF + 1);

  localparam logic [IW-1:0] c_last_idx = IW'(N_BULLET - 1);
  localparam logic [IW-1:0] c_idx_one  = IW'(1);
  localparam logic [9:0]    c_hit_r    = 10'(HIT_R);
  localparam logic [HW-1:0] c_holdoff  = HW'(HOLDOFF);
  localparam logic [HW-1:0] c_hold_one = HW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t        r_state;
  logic [9:0]    r_px_l;
  logic [9:0]    r_py_l;
  logic [IW-1:0] r_idx;
  logic          r_hit_found;
  logic [IW-1:0] r_hit_idx;
  logic [HW-1:0] r_holdoff;
  logic          r_shot;
  logic          r_kill;
  logic [IW-1:0] r_kill_idx;
  logic          r_busy;

  logic [9:0]    w_dx;
  logic [9:0]    w_dy;
  logic          w_hit;
  logic          w_found;
  logic [IW-1:0] w_sel_idx;

  // Larger-minus-smaller keeps the distance unsigned with no wrap-around.
  always_comb begin
    w_dx      = '0;
    w_dy      = '0;
    w_hit     = 1'b0;
    w_found   = 1'b0;
    w_sel_idx = '0;
    w_dx      = (pool.bullet_x >= r_px_l) ? (pool.bullet_x - r_px_l) : (r_px_l - pool.bullet_x);
    w_dy      = (pool.bullet_y >= r_py_l) ? (pool.bullet_y - r_py_l) : (r_py_l - pool.bullet_y);
    w_hit     = pool.bullet_valid && (w_dx <= c_hit_r) && (w_dy <= c_hit_r);
    w_found   = r_hit_found || w_hit;
    w_sel_idx = r_hit_found ? r_hit_idx : r_idx;
  end

  always_ff @(posedge clk_22) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_px_l      <= '0;
      r_py_l      <= '0;
      r_idx       <= '0;
      r_hit_found <= 1'b0;
      r_hit_idx   <= '0;
      r_holdoff   <= '0;
      r_shot      <= 1'b0;
      r_kill      <= 1'b0;
      r_kill_idx  <= '0;
      r_busy      <= 1'b0;
    end else begin
      // Window opens the cycle after the shot pulse so a report lands on zero at shot+HOLDOFF+1.
      if (r_state == S_REPORT && r_shot) begin
        r_holdoff <= c_holdoff;
      end else if (r_holdoff != '0) begin
        r_holdoff <= r_holdoff - c_hold_one;
      end

      case (r_state)
        S_IDLE: begin
          if (frame_tick) begin
            r_px_l      <= px;
            r_py_l      <= py;
            r_idx       <= '0;
            r_hit_found <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_SCAN;
          end
        end

        S_SCAN: begin
          if (w_hit && !r_hit_found) begin
            r_hit_found <= 1'b1;
            r_hit_idx   <= r_idx;
          end
          if (r_idx == c_last_idx) begin
            r_idx <= '0;
            if (w_found && player_alive) begin
              r_kill     <= 1'b1;
              r_kill_idx <= w_sel_idx;
              // Counter value seen during REPORT is one decrement below the current one.
              r_shot     <= (r_holdoff <= c_hold_one);
              r_state    <= S_REPORT;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_idx <= r_idx + c_idx_one;
          end
        end

        S_REPORT: begin
          r_shot     <= 1'b0;
          r_kill     <= 1'b0;
          r_kill_idx <= '0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pool.bullet_idx = r_idx;
  assign pool.kill       = r_kill;
  assign pool.kill_idx   = r_kill_idx;
  assign shot            = r_shot;
  assign busy            = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_reimu_hit_detect.sv
`default_nettype none
// ============================================================================
// Module   : tb_reimu_hit_detect
// Purpose  : Self-checking bench for reimu_hit_detect against a scan-level model.
// Revision : 1.0
// ============================================================================
module tb_reimu_hit_detect;
  localparam int N_BULLET = 8;
  localparam int HIT_R    = 4;
  localparam int HOLDOFF  = 80;
  localparam int IW       = $clog2(N_BULLET);

  logic       clk_22 = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       player_alive = 1'b1;
  logic [9:0] px = '0;
  logic [9:0] py = '0;
  logic       shot;
  logic       busy;

  reimu_hit_detect_if #(.N_BULLET(N_BULLET)) pool ();

  reimu_hit_detect #(
    .N_BULLET (N_BULLET),
    .HIT_R    (HIT_R),
    .HOLDOFF  (HOLDOFF)
  ) dut (
    .clk_22       (clk_22),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .player_alive (player_alive),
    .px           (px),
    .py           (py),
    .pool         (pool),
    .shot         (shot),
    .busy         (busy)
  );

  always #5 clk_22 = ~clk_22;

  logic       m_valid [N_BULLET];
  logic [9:0] m_x     [N_BULLET];
  logic [9:0] m_y     [N_BULLET];

  always_comb begin
    pool.bullet_valid = m_valid[pool.bullet_idx];
    pool.bullet_x     = m_x[pool.bullet_idx];
    pool.bullet_y     = m_y[pool.bullet_idx];
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit has_shot = 1'b0;
  int last_shot = 0;

  task automatic step();
    @(posedge clk_22);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic clear_pool();
    for (int i = 0; i < N_BULLET; i++) begin
      m_valid[i] = 1'b0;
      m_x[i]     = '0;
      m_y[i]     = '0;
    end
  endtask

  task automatic set_entry(input int i, input int x, input int y);
    m_valid[i] = 1'b1;
    m_x[i]     = 10'(x);
    m_y[i]     = 10'(y);
  endtask

  // One full frame scan: model predicts the report, every cycle t+1..t+N+2 is checked.
  task automatic run_scan(input string name, input bit alive, input int extra_k);
    int  exp_idx;
    bit  exp_rep;
    bit  exp_shot;
    int  t;
    int  lpx;
    int  lpy;
    bit  e_busy;
    bit  e_kill;
    bit  e_shot;
    lpx = int'(px);
    lpy = int'(py);
    exp_idx = -1;
    for (int i = 0; i < N_BULLET; i++)
      if (exp_idx < 0 && m_valid[i] && absd(int'(m_x[i]), lpx) <= HIT_R && absd(int'(m_y[i]), lpy) <= HIT_R)
        exp_idx = i;
    player_alive = alive;
    t = cyc;
    exp_rep  = (exp_idx >= 0) && alive;
    exp_shot = exp_rep && (!has_shot || ((t + N_BULLET + 1) - last_shot) > HOLDOFF);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    for (int k = 1; k <= N_BULLET + 2; k++) begin
      e_busy = (k <= N_BULLET) || (k == N_BULLET + 1 && exp_rep);
      e_kill = exp_rep && (k == N_BULLET + 1);
      e_shot = exp_shot && (k == N_BULLET + 1);
      tests++;
      if (busy !== e_busy) begin
        fails++;
        $display("FAIL %s busy at t+%0d: got %b expected %b", name, k, busy, e_busy);
      end
      tests++;
      if (pool.kill !== e_kill) begin
        fails++;
        $display("FAIL %s kill at t+%0d: got %b expected %b", name, k, pool.kill, e_kill);
      end
      tests++;
      if (shot !== e_shot) begin
        fails++;
        $display("FAIL %s shot at t+%0d: got %b expected %b", name, k, shot, e_shot);
      end
      if (e_kill) begin
        tests++;
        if (int'(pool.kill_idx) !== exp_idx) begin
          fails++;
          $display("FAIL %s kill_idx: got %0d expected %0d", name, pool.kill_idx, exp_idx);
        end
      end
      if (k <= N_BULLET) begin
        tests++;
        if (int'(pool.bullet_idx) !== k - 1) begin
          fails++;
          $display("FAIL %s bullet_idx at t+%0d: got %0d expected %0d", name, k, pool.bullet_idx, k - 1);
        end
      end
      // Player position moves mid-scan; only the value latched at the tick may matter.
      px = 10'($urandom);
      py = 10'($urandom);
      frame_tick = (k == extra_k);
      if (k < N_BULLET + 2) step();
    end
    frame_tick = 1'b0;
    px = 10'(lpx);
    py = 10'(lpy);
    if (exp_shot) begin
      has_shot  = 1'b1;
      last_shot = t + N_BULLET + 1;
    end
  endtask

  task automatic check_all_zero(input string name);
    tests++;
    if ({shot, pool.kill, busy} !== 3'b000 || pool.kill_idx !== '0 || pool.bullet_idx !== '0) begin
      fails++;
      $display("FAIL %s outputs: got shot=%b kill=%b busy=%b kill_idx=%0d bullet_idx=%0d required all 0",
               name, shot, pool.kill, busy, pool.kill_idx, pool.bullet_idx);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    check_all_zero("reset");
    rst = 1'b0;
    has_shot = 1'b0;
    step();
  endtask

  task automatic test_single_hit();
    clear_pool();
    px = 10'd100; py = 10'd200;
    set_entry(3, 103, 196);
    run_scan("single_hit", 1'b1, 0);
  endtask

  task automatic test_edges();
    clear_pool();
    px = 10'd100; py = 10'd200;
    set_entry(0, 104, 204);
    run_scan("edge_corner", 1'b1, 0);
    set_entry(0, 105, 200);
    run_scan("edge_miss", 1'b1, 0);
    set_entry(0, 96, 200);
    run_scan("edge_low_side", 1'b1, 0);
    set_entry(0, 100, 195);
    run_scan("edge_miss_y", 1'b1, 0);
  endtask

  task automatic test_multi_hit();
    idle(HOLDOFF);
    clear_pool();
    px = 10'd300; py = 10'd50;
    set_entry(2, 301, 52);
    set_entry(5, 300, 50);
    set_entry(7, 296, 54);
    run_scan("multi_hit", 1'b1, 0);
  endtask

  task automatic test_holdoff();
    idle(HOLDOFF + 20);
    clear_pool();
    px = 10'd500; py = 10'd500;
    set_entry(1, 502, 498);
    run_scan("holdoff_first", 1'b1, 0);
    idle(10);
    run_scan("holdoff_plus20", 1'b1, 0);
    idle(50);
    run_scan("holdoff_plus80", 1'b1, 0);
    run_scan("holdoff_plus90", 1'b1, 0);
  endtask

  task automatic test_dead_invalid();
    idle(HOLDOFF + 20);
    clear_pool();
    px = 10'd10; py = 10'd10;
    set_entry(4, 10, 10);
    run_scan("dead_player", 1'b0, 0);
    m_valid[4] = 1'b0;
    run_scan("invalid_entry", 1'b1, 0);
  endtask

  task automatic test_reset_mid_scan();
    idle(HOLDOFF + 20);
    clear_pool();
    px = 10'd700; py = 10'd700;
    set_entry(0, 700, 700);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    idle(4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("rst_mid_scan");
    has_shot = 1'b0;
    for (int k = 7; k <= 12; k++) begin
      step();
      tests++;
      if (shot !== 1'b0 || pool.kill !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL rst_after t+%0d: got shot=%b kill=%b busy=%b required 0", k, shot, pool.kill, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_pool();
    px = 10'd900; py = 10'd100;
    set_entry(6, 903, 103);
    run_scan("overlap_tick", 1'b1, 4);
    run_scan("back_to_back", 1'b1, 0);
  endtask

  task automatic test_random();
    int cx;
    int cy;
    for (int n = 0; n < 40; n++) begin
      idle(int'($urandom_range(0, 40)));
      clear_pool();
      cx = 20 + int'($urandom_range(0, 980));
      cy = 20 + int'($urandom_range(0, 980));
      px = 10'(cx);
      py = 10'(cy);
      for (int i = 0; i < N_BULLET; i++) begin
        m_valid[i] = ($urandom_range(0, 2) != 0);
        m_x[i]     = 10'(cx + int'($urandom_range(0, 16)) - 8);
        m_y[i]     = 10'(cy + int'($urandom_range(0, 16)) - 8);
      end
      run_scan("random", ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, N_BULLET)) : 0);
    end
  endtask

  initial begin
    clear_pool();
    test_reset();
    test_single_hit();
    test_edges();
    test_multi_hit();
    test_holdoff();
    test_dead_invalid();
    test_reset_mid_scan();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
